minimig_bank_arbiter: RTL and testbench
=======================================

MINIMIG_BANK_ARBITER -- requirements
Module: minimig_bank_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: watchdog limit in clk cycles for an outstanding memory access (8-bit, 1..255).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  request per requester; [0]=chipset DMA, [1]=CPU, [2]=aux (RTG/cache refill).
REQ-005 req_we  input  3  write enable per requester.
REQ-006 req_addr  input  69  three 23-bit word addresses packed {aux,cpu,dma}.
REQ-007 req_wdata  input  48  three 16-bit write words packed {aux,cpu,dma}.
REQ-008 req_bank  input  24  three 8-bit bank selects from the bank mapper packed {aux,cpu,dma}.
REQ-009 ack  output  3  one-cycle completion pulse per requester.
REQ-010 err  output  3  one-cycle error pulse per requester; coincident with ack.
REQ-011 rdata  output  16  read data, valid in the ack cycle.
REQ-012 mem_req, mem_we  output  1 each  memory request/write strobe.
REQ-013 mem_addr  output  23; mem_wdata  output  16; mem_bank  output  8.
REQ-014 mem_ack  input  1; mem_rdata  input  16  memory completion and read data.

Function
REQ-015 States IDLE, ISSUE, WAIT, DONE; the FSM SHALL sample req only in IDLE.
REQ-016 Priority: DMA SHALL always win; CPU and aux SHALL round-robin, with a last-winner bit toggling only on a CPU/aux grant.
REQ-017 IDLE->ISSUE on any req; the winner's index, we, addr, wdata and bank SHALL be latched in that cycle.
REQ-018 Latched bank==8'h00 (unmapped): IDLE->DONE directly, no mem_req, ack and err SHALL pulse, rdata SHALL be 16'h0000.
REQ-019 ISSUE: mem_req=1 with latched mem_we/addr/wdata/bank for exactly one cycle, then ->WAIT.
REQ-020 WAIT: mem_req SHALL stay 0; on mem_ack, mem_rdata SHALL be captured into rdata and ->DONE.
REQ-021 mem_ack in the ISSUE cycle SHALL be honoured identically (ISSUE->DONE).
REQ-022 DONE: ack[idx]=1 for one cycle, then ->IDLE; minimum latency req-to-ack is 3 cycles for mapped access.
REQ-023 A requester SHALL hold req until its ack; req dropped before ack SHALL NOT abort the access.
REQ-024 mem_ack in IDLE or DONE SHALL be ignored.
REQ-025 rdata SHALL hold its value until the next capture; writes SHALL leave rdata unchanged.

Reset
REQ-026 Synchronous reset SHALL force IDLE, ack=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_bank=0, last-winner=aux (so CPU wins first).
REQ-027 Reset mid-access SHALL abandon the transaction without ack; a later mem_ack SHALL be ignored.

Configuration
REQ-028 Macro MINIMIG_BANK_ARB_TIMEOUT_EN: when defined, an 8-bit counter cleared in ISSUE SHALL count in WAIT; reaching TIMEOUT SHALL force DONE with ack+err pulsed and rdata=16'hFFFF.
REQ-029 Without the macro, WAIT SHALL persist indefinitely until mem_ack; err SHALL pulse only for unmapped banks.

Structure
REQ-030 Shared package minimig_arb_pkg SHALL hold the state enum, requester index constants (DMA=0, CPU=1, AUX=2) and the unmapped-bank constant 8'h00.
REQ-031 Priority/round-robin selection SHALL be one sub-module minimig_arb_pick (combinational winner + index).

Verification
REQ-032 reset, req=3'b011 both mapped -> DMA issued first (mem_req cycle 2), ack=3'b001 at cycle 3 with mem_ack at cycle 2; CPU served next.
REQ-033 req=3'b110 held for 4 accesses, mem_ack 1 cycle after mem_req -> grants CPU, aux, CPU, aux.
REQ-034 CPU read addr 23'h000100 bank 8'h10, mem_rdata=16'hA55A -> rdata=16'hA55A with ack[1].
REQ-035 aux request bank 8'h00 -> no mem_req, ack[2]=err[2]=1, rdata=16'h0000.
REQ-036 With TIMEOUT_EN, TIMEOUT=4, no mem_ack -> ack[1]=err[1]=1 after 4 WAIT cycles, rdata=16'hFFFF.
REQ-037 Reset asserted in WAIT, mem_ack next cycle -> no ack, FSM in IDLE.

Source files
------------

// File: rtl/minimig_arb_pkg.sv
// rtl/minimig_arb_pkg.sv - shared types and constants for the minimig bank arbiter
package minimig_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam logic [1:0] IDX_DMA = 2'd0;
  localparam logic [1:0] IDX_CPU = 2'd1;
  localparam logic [1:0] IDX_AUX = 2'd2;

  localparam logic [7:0] BANK_UNMAPPED = 8'h00;

  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/minimig_bank_arbiter_if.sv
// rtl/minimig_bank_arbiter_if.sv - requester-side bus of the bank arbiter, fields packed {aux,cpu,dma}
interface minimig_bank_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [68:0] req_addr;
  logic [47:0] req_wdata;
  logic [23:0] req_bank;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [15:0] rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, req_bank,
    input  ack, err, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_bank,
    output ack, err, rdata
  );
endinterface

// File: rtl/minimig_bank_arbiter_pick.sv
// rtl/minimig_bank_arbiter_pick.sv - winner selection: DMA fixed priority, CPU/aux round-robin
module minimig_arb_pick
  import minimig_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       last_aux,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = IDX_DMA;
    if (req[0]) begin
      idx = IDX_DMA;
    end else if (req[1] && req[2]) begin
      idx = last_aux ? IDX_CPU : IDX_AUX;
    end else if (req[1]) begin
      idx = IDX_CPU;
    end else if (req[2]) begin
      idx = IDX_AUX;
    end
  end

endmodule

// File: rtl/minimig_bank_arbiter.sv
// rtl/minimig_bank_arbiter.sv - three-requester memory bank arbiter (IDLE/ISSUE/WAIT/DONE)
// Optional watchdog on outstanding accesses: MINIMIG_BANK_ARB_TIMEOUT_EN.
module minimig_bank_arbiter
  import minimig_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  minimig_bank_arbiter_if.slave       bus,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [22:0]                 mem_addr,
  output logic [15:0]                 mem_wdata,
  output logic [7:0]                  mem_bank,
  input  logic                        mem_ack,
  input  logic [15:0]                 mem_rdata
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  arb_state_t  state, state_nxt;
  logic [1:0]  idx_q;
  logic        err_q;
  logic        last_aux;
  logic [15:0] rdata_q;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        win_we;
  logic [22:0] win_addr;
  logic [15:0] win_wdata;
  logic [7:0]  win_bank;

  minimig_arb_pick u_pick (
    .req      (bus.req),
    .last_aux (last_aux),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    win_we    = bus.req_we[0];
    win_addr  = bus.req_addr[22:0];
    win_wdata = bus.req_wdata[15:0];
    win_bank  = bus.req_bank[7:0];
    case (pick_idx)
      IDX_CPU: begin
        win_we    = bus.req_we[1];
        win_addr  = bus.req_addr[45:23];
        win_wdata = bus.req_wdata[31:16];
        win_bank  = bus.req_bank[15:8];
      end
      IDX_AUX: begin
        win_we    = bus.req_we[2];
        win_addr  = bus.req_addr[68:46];
        win_wdata = bus.req_wdata[47:32];
        win_bank  = bus.req_bank[23:16];
      end
      default: ;
    endcase
  end

`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = (win_bank == BANK_UNMAPPED) ? DONE : ISSUE;
        end
      end
      ISSUE: state_nxt = mem_ack ? DONE : WAIT;
      WAIT: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end
`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == ISSUE);
    bus.ack   = (state == DONE) ? idx_onehot(idx_q) : 3'b000;
    bus.err   = (state == DONE && err_q) ? idx_onehot(idx_q) : 3'b000;
    bus.rdata = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= IDX_DMA;
      err_q     <= 1'b0;
      last_aux  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bank  <= '0;
      rdata_q   <= '0;
`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx_q     <= pick_idx;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_bank  <= win_bank;
            err_q     <= (win_bank == BANK_UNMAPPED);
            if (win_bank == BANK_UNMAPPED) begin
              rdata_q <= '0;
            end
            // DMA grants leave the CPU/aux rotation untouched
            if (pick_idx != IDX_DMA) begin
              last_aux <= (pick_idx == IDX_AUX);
            end
          end
        end
        ISSUE: begin
`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (mem_ack && !mem_we) begin
            rdata_q <= mem_rdata;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (!mem_we) begin
              rdata_q <= mem_rdata;
            end
          end
`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 16'hFFFF;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minimig_bank_arbiter.sv
// tb/tb_minimig_bank_arbiter.sv - scoreboard bench for minimig_bank_arbiter
module tb_minimig_bank_arbiter;
  import minimig_arb_pkg::*;

`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_bank;

  minimig_bank_arbiter_if bus ();

  minimig_bank_arbiter #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bank  (mem_bank),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_seen = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int memreq_cyc = 0;
  logic [47:0] mem_q[$];
  logic [21:0] exp_q[$];

  int          ack_delay = 0;
  logic [15:0] mem_data = 16'h0000;
  int          manual_req = 0;
  logic [15:0] manual_data = 16'h0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [22:0] a, input logic [15:0] d, input logic [7:0] b);
    mem_q.push_back({we, a, d, b});
  endtask

  task automatic exp_rsp(input logic [2:0] a, input logic [2:0] e, input logic [15:0] r);
    exp_q.push_back({a, e, r});
  endtask

  // monitor: pops expectations whenever the DUT presents a memory request or a completion
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (mem_req !== 1'b0) begin
        memreq_cyc = cyc;
        if (mem_q.size() == 0) check("mem_req_unexpected", {mem_we, mem_addr, mem_wdata, mem_bank}, 0);
        else check("mem_issue", {mem_we, mem_addr, mem_wdata, mem_bank}, mem_q.pop_front());
      end
      if (bus.ack !== 3'b000) begin
        ack_seen++;
        ack_cyc = cyc;
        if (exp_q.size() == 0) check("ack_unexpected", {bus.ack, bus.err, bus.rdata}, 0);
        else check("ack_resp", {bus.ack, bus.err, bus.rdata}, exp_q.pop_front());
      end
    end
  end

  // memory model: acks ack_delay cycles after mem_req, or once per manual_req bump
  initial begin
    int cnt = 0;
    int manual_done = 0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (manual_req != manual_done) begin
        manual_done = manual_req;
        mem_ack = 1'b1;
        mem_rdata = manual_data;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_data;
        end
      end else if (mem_req === 1'b1 && ack_delay >= 0) begin
        if (ack_delay == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_data;
        end else begin
          cnt = ack_delay;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_acks(input string name, input int n, input bit drop, input int budget);
    int start = ack_seen;
    int k = 0;
    while (ack_seen - start < n && k < budget) begin
      @(negedge clk);
      #1;
      if (drop) bus.req = bus.req & ~bus.ack;
      k++;
    end
    if (!drop) bus.req = 3'b000;
    check(name, ack_seen - start, n);
  endtask

  initial begin
    int lat;
    int start;
    int k;
    bus.req = 3'b000;
    bus.req_we = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_bank = '0;

    do_reset();
    #1;
    check("rst_ack", bus.ack, 3'b000);
    check("rst_err", bus.err, 3'b000);
    check("rst_rdata", bus.rdata, 16'h0000);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 23'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_mem_bank", mem_bank, 8'h0);
    @(negedge clk);

    // DMA beats CPU; mem_ack during ISSUE; ack in third cycle counting the request cycle
    ack_delay = 0;
    mem_data = 16'h1234;
    bus.req_addr = {23'h000000, 23'h000100, 23'h000010};
    bus.req_wdata = {16'h0000, 16'h2222, 16'h1111};
    bus.req_bank = {8'h00, 8'h10, 8'h01};
    bus.req_we = 3'b000;
    exp_mem(1'b0, 23'h000010, 16'h1111, 8'h01);
    exp_rsp(3'b001, 3'b000, 16'h1234);
    exp_mem(1'b0, 23'h000100, 16'h2222, 8'h10);
    exp_rsp(3'b010, 3'b000, 16'h1234);
    bus.req = 3'b011;
    lat = 1;
    while (bus.ack === 3'b000 && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("dma_first_latency", lat, 3);
    bus.req = bus.req & ~bus.ack;
    wait_acks("cpu_after_dma", 1, 1'b1, 20);

    // CPU/aux round-robin from reset, aux writes leave rdata alone
    do_reset();
    ack_delay = 1;
    mem_data = 16'h0F0F;
    bus.req_addr = {23'h7FFFFF, 23'h000100, 23'h000000};
    bus.req_wdata = {16'hC0DE, 16'h2222, 16'h0000};
    bus.req_bank = {8'hFF, 8'h10, 8'h01};
    bus.req_we = 3'b100;
    for (int i = 0; i < 2; i++) begin
      exp_mem(1'b0, 23'h000100, 16'h2222, 8'h10);
      exp_rsp(3'b010, 3'b000, 16'h0F0F);
      exp_mem(1'b1, 23'h7FFFFF, 16'hC0DE, 8'hFF);
      exp_rsp(3'b100, 3'b000, 16'h0F0F);
    end
    bus.req = 3'b110;
    wait_acks("rr_four", 4, 1'b0, 100);
    @(negedge clk);

    // CPU read data capture
    ack_delay = 0;
    mem_data = 16'hA55A;
    bus.req_we = 3'b000;
    exp_mem(1'b0, 23'h000100, 16'h2222, 8'h10);
    exp_rsp(3'b010, 3'b000, 16'hA55A);
    bus.req = 3'b010;
    wait_acks("cpu_read", 1, 1'b1, 20);

    // stray mem_ack while idle is ignored
    manual_data = 16'hFFEE;
    manual_req++;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ack_rdata", bus.rdata, 16'hA55A);

    // unmapped aux bank
    bus.req_addr = {23'h123456, 23'h000100, 23'h000010};
    bus.req_bank = {8'h00, 8'h10, 8'h01};
    exp_rsp(3'b100, 3'b100, 16'h0000);
    bus.req = 3'b100;
    wait_acks("aux_unmapped", 1, 1'b1, 20);

    // DMA write, slower memory, rdata unchanged
    ack_delay = 2;
    mem_data = 16'h9999;
    bus.req_addr = {23'h000000, 23'h000100, 23'h400001};
    bus.req_wdata = {16'h0000, 16'h2222, 16'h1357};
    bus.req_bank = {8'h00, 8'h10, 8'h80};
    bus.req_we = 3'b001;
    exp_mem(1'b1, 23'h400001, 16'h1357, 8'h80);
    exp_rsp(3'b001, 3'b000, 16'h0000);
    bus.req = 3'b001;
    wait_acks("dma_write", 1, 1'b1, 20);

    // no mem_ack: watchdog or indefinite wait
    ack_delay = -1;
    bus.req_we = 3'b000;
    exp_mem(1'b0, 23'h000100, 16'h2222, 8'h10);
`ifdef MINIMIG_BANK_ARB_TIMEOUT_EN
    exp_rsp(3'b010, 3'b010, 16'hFFFF);
    bus.req = 3'b010;
    wait_acks("timeout_ack", 1, 1'b1, 40);
    check("timeout_wait_cycles", ack_cyc - memreq_cyc, 5);
`else
    bus.req = 3'b010;
    start = ack_seen;
    repeat (30) @(negedge clk);
    #1;
    check("wait_persists", ack_seen - start, 0);
    exp_rsp(3'b010, 3'b000, 16'h6789);
    manual_data = 16'h6789;
    manual_req++;
    wait_acks("late_mem_ack", 1, 1'b1, 20);
`endif
    @(negedge clk);

    // reset in WAIT abandons the access; the following mem_ack is ignored
    exp_mem(1'b0, 23'h000100, 16'h2222, 8'h10);
    bus.req = 3'b010;
    start = ack_seen;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst_wait_issue_seen", mem_req, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.req = 3'b000;
    manual_data = 16'h4242;
    manual_req++;
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_wait_no_ack", ack_seen - start, 0);
    check("rst_wait_idle", dut.state, IDLE);
    check("rst_wait_rdata", bus.rdata, 16'h0000);
    check("rst_wait_mem_req", mem_req, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
